// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - UART receive deframer (8N1; 8E1/8O1 when UART_RX_PARITY_EN is defined)
module uart_rx #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_rx,
  input  logic       i_rx_strb,
  output logic       o_rx_strb_en,
  input  logic       i_parity_odd,
  output logic [7:0] o_data,
  output logic       o_valid,
  input  logic       i_ready,
  output logic       o_frame_err,
  output logic       o_parity_err,
  output logic       o_overrun
);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t                 r_state, w_state_nxt;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_rx_d;
  logic                   w_rx_s;
  logic [7:0]             r_shift, w_shift_nxt;
  logic [2:0]             r_cnt, w_cnt_nxt;
  logic                   r_perr, w_perr_nxt;
  logic                   w_deliver, w_ferr, w_perr_pulse;
  logic                   r_strb_en, r_valid, r_ferr, r_perr_p, r_ovr;
  logic [7:0]             r_data;

  assign w_rx_s = r_sync[SYNC_STAGES-1];

`ifndef UART_RX_PARITY_EN
  logic w_unused_parity_odd;
  assign w_unused_parity_odd = i_parity_odd;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '1;
      r_rx_d <= 1'b1;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_rx};
      r_rx_d <= w_rx_s;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_shift <= 8'h00;
      r_cnt   <= 3'd0;
      r_perr  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_shift <= w_shift_nxt;
      r_cnt   <= w_cnt_nxt;
      r_perr  <= w_perr_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_shift_nxt  = r_shift;
    w_cnt_nxt    = r_cnt;
    w_perr_nxt   = r_perr;
    w_deliver    = 1'b0;
    w_ferr       = 1'b0;
    w_perr_pulse = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_rx_d && !w_rx_s) w_state_nxt = S_START;
      end
      S_START: begin
        if (i_rx_strb) begin
          w_perr_nxt = 1'b0;
          if (!w_rx_s) begin
            w_state_nxt = S_DATA;
            w_cnt_nxt   = 3'd0;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      S_DATA: begin
        if (i_rx_strb) begin
          w_shift_nxt = {w_rx_s, r_shift[7:1]};
          w_cnt_nxt   = r_cnt + 3'd1;
          if (r_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            w_state_nxt = S_PARITY;
`else
            w_state_nxt = S_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (i_rx_strb) begin
          w_perr_nxt  = (w_rx_s != (^r_shift ^ i_parity_odd));
          w_state_nxt = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (i_rx_strb) begin
          w_state_nxt = S_IDLE;
          if (!w_rx_s)     w_ferr       = 1'b1;
          else if (r_perr) w_perr_pulse = 1'b1;
          else             w_deliver    = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output register: a new byte may replace the old one only in the cycle it is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_strb_en <= 1'b0;
      r_valid   <= 1'b0;
      r_data    <= 8'h00;
      r_ferr    <= 1'b0;
      r_perr_p  <= 1'b0;
      r_ovr     <= 1'b0;
    end else begin
      r_strb_en <= (w_state_nxt != S_IDLE);
      r_ferr    <= w_ferr;
      r_perr_p  <= w_perr_pulse;
      r_ovr     <= 1'b0;
      if (w_deliver && (!r_valid || i_ready)) begin
        r_data  <= r_shift;
        r_valid <= 1'b1;
      end else if (w_deliver) begin
        r_ovr <= 1'b1;
      end else if (r_valid && i_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign o_rx_strb_en = r_strb_en;
  assign o_valid      = r_valid;
  assign o_data       = r_data;
  assign o_frame_err  = r_ferr;
  assign o_parity_err = r_perr_p;
  assign o_overrun    = r_ovr;

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - randomized self-checking bench for uart_rx against a frame-level model
`timescale 1ns/1ps
module tb_uart_rx;
  localparam int BIT = 16;
  localparam int MID = 5;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       i_rx = 1'b1;
  logic       i_rx_strb;
  logic       o_rx_strb_en;
  logic       i_parity_odd = 1'b0;
  logic [7:0] o_data;
  logic       o_valid;
  logic       i_ready = 1'b1;
  logic       o_frame_err, o_parity_err, o_overrun;

  uart_rx #(.SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .i_rx(i_rx), .i_rx_strb(i_rx_strb),
    .o_rx_strb_en(o_rx_strb_en), .i_parity_odd(i_parity_odd),
    .o_data(o_data), .o_valid(o_valid), .i_ready(i_ready),
    .o_frame_err(o_frame_err), .o_parity_err(o_parity_err), .o_overrun(o_overrun)
  );

  always #5 clk = ~clk;

  // Baud generator stand-in: counter restarts whenever the receiver disables it.
  int unsigned bcnt;
  always @(posedge clk) begin
    if (!o_rx_strb_en) bcnt <= 0;
    else               bcnt <= bcnt + 1;
  end
  assign i_rx_strb = o_rx_strb_en && ((bcnt % BIT) == MID);

  int n_ferr = 0, n_perr = 0, n_ovr = 0, n_vcyc = 0;
  logic [7:0] got_q[$];
  always @(negedge clk) begin
    if (rst_n) begin
      if (o_valid && i_ready) got_q.push_back(o_data);
      if (o_valid) n_vcyc++;
      if (o_frame_err) n_ferr++;
      if (o_parity_err) n_perr++;
      if (o_overrun) n_ovr++;
    end
  end

  int e_ferr = 0, e_perr = 0, e_ovr = 0;
  bit m_full = 1'b0;
  logic [7:0] exp_q[$];
  int n_err = 0, n_chk = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic bit good_par(input logic [7:0] d);
    return ^d ^ i_parity_odd;
  endfunction

  task automatic model_frame(input logic [7:0] d, input bit stopb, input bit parb);
    if (!stopb) e_ferr++;
    else if (PAR && (parb != good_par(d))) e_perr++;
    else if (m_full) e_ovr++;
    else begin
      exp_q.push_back(d);
      if (!i_ready) m_full = 1'b1;
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input bit stopb, input bit parb, input int gap);
    i_rx = 1'b0; tick(BIT);
    for (int i = 0; i < 8; i++) begin i_rx = d[i]; tick(BIT); end
    if (PAR) begin i_rx = parb; tick(BIT); end
    i_rx = stopb; tick(BIT);
    i_rx = 1'b1; tick(gap);
    model_frame(d, stopb, parb);
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_ferr"}, n_ferr, e_ferr);
    chk({tag, "_perr"}, n_perr, e_perr);
    chk({tag, "_ovr"}, n_ovr, e_ovr);
    chk({tag, "_nbytes"}, got_q.size(), exp_q.size());
    while (got_q.size() > 0 && exp_q.size() > 0)
      chk({tag, "_byte"}, got_q.pop_front(), exp_q.pop_front());
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic chk_outs_zero(input string tag);
    chk({tag, "_valid"}, o_valid, 0);
    chk({tag, "_data"}, o_data, 0);
    chk({tag, "_strb_en"}, o_rx_strb_en, 0);
    chk({tag, "_errs"}, {o_frame_err, o_parity_err, o_overrun}, 0);
  endtask

  initial begin
    int v0;
    logic [7:0] d;
    bit sb, pb;

    tick(5);
    chk_outs_zero("reset");
    rst_n = 1'b1;
    tick(5);

    v0 = n_vcyc;
    send_frame(8'hA5, 1'b1, good_par(8'hA5), BIT);
    chk("a5_vcyc", n_vcyc - v0, 1);
    chk("a5_valid_low", o_valid, 0);
    check_all("a5");

    i_ready = 1'b0;
    send_frame(8'h3C, 1'b1, good_par(8'h3C), BIT);
    send_frame(8'hC3, 1'b1, good_par(8'hC3), BIT);
    chk("ovr_valid", o_valid, 1);
    chk("ovr_data", o_data, 8'h3C);
    chk("ovr_cnt", n_ovr, 1);
    i_ready = 1'b1;
    tick(1);
    m_full = 1'b0;
    chk("ovr_valid_drop", o_valid, 0);
    check_all("ovr");

    send_frame(8'h55, 1'b0, good_par(8'h55), BIT);
    chk("ferr_valid", o_valid, 0);
    check_all("ferr");

    i_rx = 1'b0; tick(20 * BIT);
    i_rx = 1'b1; tick(2 * BIT);
    e_ferr++;
    chk("break_strb_en", o_rx_strb_en, 0);
    check_all("break");

    i_rx = 1'b0; tick(5);
    i_rx = 1'b1; tick(BIT);
    chk("glitch_strb_en", o_rx_strb_en, 0);
    check_all("glitch");

`ifdef UART_RX_PARITY_EN
    i_parity_odd = 1'b0;
    send_frame(8'h07, 1'b1, 1'b1, BIT);
    check_all("par_ok");
    send_frame(8'h07, 1'b1, 1'b0, BIT);
    check_all("par_bad");
`endif

    // Park a byte in the output register, then reset in the middle of a frame.
    i_parity_odd = 1'b1;
    i_ready = 1'b0;
    send_frame(8'h9A, 1'b1, good_par(8'h9A), BIT);
    chk("pre_rst_valid", o_valid, 1);
    i_rx = 1'b0; tick(BIT);
    for (int i = 0; i < 4; i++) begin i_rx = 1'b1; tick(BIT); end
    tick(BIT / 2);
    rst_n = 1'b0;
    #1;
    chk_outs_zero("midrst");
    void'(exp_q.pop_back());
    m_full = 1'b0;
    i_ready = 1'b1;
    tick(2);
    rst_n = 1'b1;
    tick(BIT / 2 - 2 + 3 * BIT + (PAR ? BIT : 0) + 2 * BIT);
    check_all("post_rst_idle");
    send_frame(8'h12, 1'b1, good_par(8'h12), BIT);
    check_all("post_rst_12");

    for (int k = 0; k < 40; k++) begin
      i_parity_odd = 1'($urandom_range(0, 1));
      d  = 8'($urandom);
      sb = ($urandom_range(0, 7) != 0);
      pb = good_par(d) ^ ($urandom_range(0, 3) == 0);
      send_frame(d, sb, pb, sb ? $urandom_range(0, BIT) : 2 + $urandom_range(0, BIT));
      check_all($sformatf("rnd%0d", k));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
